ram_port_arbiter: RTL and testbench

//   Shares one single-port synchronous RAM between the execution unit (separate read and

---
 rtl/ram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port synchronous RAM between the CPU (separate read and
// write ports, never stalled) and a DMA requester that uses idle RAM cycles.
// Read data is steered back to its issuer by a registered owner tag.
module ram_port_arbiter #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_rd_en,
  input  logic [ADDR_BITS-1:0] cpu_rd_addr,
  output logic [DATA_BITS-1:0] cpu_rd_data,
  input  logic                 cpu_wr_en,
  input  logic [ADDR_BITS-1:0] cpu_wr_addr,
  input  logic [DATA_BITS-1:0] cpu_wr_data,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [ADDR_BITS-1:0] dma_addr,
  input  logic [DATA_BITS-1:0] dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [DATA_BITS-1:0] dma_rdata,
  output logic                 dma_starved,
  output logic                 conflict_err,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  logic                 wr_sel_s;
  logic                 rd_sel_s;
  logic                 dma_sel_s;
  owner_t               owner_nxt_s;
  owner_t               rsp_owner_r;
  logic [DATA_BITS-1:0] hold_r;
  logic [DATA_BITS-1:0] dma_rdata_r;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic [CNT_W-1:0]     wait_nxt_s;
  logic                 conflict_r;

  // Fixed-priority select (cpu_wr > cpu_rd > dma); nothing is selected while reset is held.
  always_comb begin
    wr_sel_s  = reset & cpu_wr_en;
    rd_sel_s  = reset & cpu_rd_en & ~cpu_wr_en;
    dma_sel_s = reset & dma_req & ~cpu_wr_en & ~cpu_rd_en;
  end

  // Drive the RAM from the winning request; idle port is all-zero to keep waves clean.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {ADDR_BITS{1'b0}};
    ram_wdata = {DATA_BITS{1'b0}};
    if (wr_sel_s) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = cpu_wr_addr;
      ram_wdata = cpu_wr_data;
    end else if (rd_sel_s) begin
      ram_en    = 1'b1;
      ram_addr  = cpu_rd_addr;
    end else if (dma_sel_s) begin
      ram_en    = 1'b1;
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else begin
      ram_en    = 1'b0;
    end
  end

  // Owner of the read issued this cycle, and next value of the DMA wait counter.
  always_comb begin
    owner_nxt_s = OWN_NONE;
    wait_nxt_s  = {CNT_W{1'b0}};
    if (rd_sel_s) begin
      owner_nxt_s = OWN_CPU;
    end else if (dma_sel_s && !dma_we) begin
      owner_nxt_s = OWN_DMA;
    end else begin
      owner_nxt_s = OWN_NONE;
    end
    if (dma_req && !dma_sel_s) begin
      if (wait_cnt_r == CNT_MAX) begin
        wait_nxt_s = wait_cnt_r;
      end else begin
        wait_nxt_s = wait_cnt_r + CNT_W'(1);
      end
    end else begin
      wait_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Owner tag, read-data holding registers, wait counter and sticky conflict flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_owner_r <= OWN_NONE;
      hold_r      <= {DATA_BITS{1'b0}};
      dma_rdata_r <= {DATA_BITS{1'b0}};
      wait_cnt_r  <= {CNT_W{1'b0}};
      conflict_r  <= 1'b0;
    end else begin
      rsp_owner_r <= owner_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
      if (rsp_owner_r == OWN_CPU) begin
        hold_r <= ram_rdata;
      end
      if (rsp_owner_r == OWN_DMA) begin
        dma_rdata_r <= ram_rdata;
      end
      if (cpu_wr_en && cpu_rd_en) begin
        conflict_r <= 1'b1;
      end
    end
  end

  // Route the RAM response to its owner; the other side sees its held value.
  always_comb begin
    cpu_rd_data  = hold_r;
    dma_rvalid   = 1'b0;
    dma_rdata    = dma_rdata_r;
    case (rsp_owner_r)
      OWN_CPU: cpu_rd_data = ram_rdata;
      OWN_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = ram_rdata;
      end
      default: begin
        cpu_rd_data = hold_r;
        dma_rvalid  = 1'b0;
      end
    endcase
    dma_gnt      = dma_sel_s;
    dma_starved  = (wait_cnt_r == CNT_MAX);
    conflict_err = conflict_r;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed scenarios followed by randomized traffic. A behavioural RAM sits on
// the ram_* port; a reference model (plain array + priority rules) predicts the
// port selection and queues expected read responses, which a separate monitor
// pops and compares against what the DUT returns.
module tb_ram_port_arbiter;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd_en, cpu_wr_en, dma_req, dma_we;
  logic [AB-1:0] cpu_rd_addr, cpu_wr_addr, dma_addr;
  logic [DB-1:0] cpu_wr_data, dma_wdata;
  logic [DB-1:0] cpu_rd_data, dma_rdata, ram_wdata;
  logic [DB-1:0] ram_rdata = 8'h00;
  logic          dma_gnt, dma_rvalid, dma_starved, conflict_err, ram_en, ram_we;
  logic [AB-1:0] ram_addr;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  typedef struct {int due; logic [DB-1:0] d;} rsp_t;
  rsp_t cpu_q[$];
  rsp_t dma_q[$];

  logic [DB-1:0] mem     [256];
  logic [DB-1:0] ref_mem [256];
  bit            mem_ready = 1'b0;
  int            ref_wait = 0;
  bit            ref_conflict = 1'b0;

  // Reference model state for the random DMA requester
  logic          r_dq = 1'b0, r_dwe = 1'b0;
  logic [AB-1:0] r_da = 8'h00;
  logic [DB-1:0] r_dwd = 8'h00;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dma_starved(dma_starved), .conflict_err(conflict_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DB-1:0] init_byte(input int i);
    logic [7:0] v;
    if (i == 16) v = 8'hA5;
    else if (i == 32) v = 8'h3C;
    else v = 8'(i * 37 + 11);
    return v;
  endfunction

  // Behavioural single-port synchronous RAM, 1-cycle registered read
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_ready <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check combinational selection, advance model
  task automatic step(input logic rs, input logic wr, input logic [7:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [7:0] ra,
                      input logic dq, input logic dwe, input logic [7:0] da, input logic [7:0] dwd);
    logic gnt;
    @(negedge clk);
    reset = rs; cpu_wr_en = wr; cpu_wr_addr = wa; cpu_wr_data = wd;
    cpu_rd_en = rd; cpu_rd_addr = ra;
    dma_req = dq; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    #1;
    if (!rs) begin
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_starved", dma_starved, 0);
      chk("rst_conflict", conflict_err, 0);
      ref_wait = 0;
      ref_conflict = 1'b0;
    end else begin
      gnt = dq && !wr && !rd;
      chk("dma_gnt", dma_gnt, gnt);
      chk("dma_starved", dma_starved, ref_wait == LIM);
      chk("conflict_err", conflict_err, ref_conflict);
      chk("ram_en", ram_en, wr || rd || dq);
      if (wr) begin
        chk("ram_we_w", ram_we, 1);
        chk("ram_addr_w", ram_addr, wa);
        chk("ram_wdata_w", ram_wdata, wd);
        ref_mem[wa] = wd;
      end else if (rd) begin
        chk("ram_we_r", ram_we, 0);
        chk("ram_addr_r", ram_addr, ra);
        cpu_q.push_back('{cyc + 1, ref_mem[ra]});
      end else if (dq) begin
        chk("ram_we_d", ram_we, dwe);
        chk("ram_addr_d", ram_addr, da);
        if (dwe) begin
          chk("ram_wdata_d", ram_wdata, dwd);
          ref_mem[da] = dwd;
        end else begin
          dma_q.push_back('{cyc + 1, ref_mem[da]});
        end
      end else begin
        chk("idle_addr", ram_addr, 0);
        chk("idle_wdata", ram_wdata, 0);
      end
      if (dq && !gnt) ref_wait = (ref_wait < LIM) ? ref_wait + 1 : LIM;
      else ref_wait = 0;
      if (wr && rd) ref_conflict = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops expected read responses when due and checks both read ports
  initial begin
    logic [DB-1:0] cpu_last, dma_last;
    bit exp_v;
    cpu_last = 8'h00;
    dma_last = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b1) begin
        cpu_q.delete();
        dma_q.delete();
        cpu_last = 8'h00;
        dma_last = 8'h00;
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rd_data", cpu_rd_data, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
      end else begin
        if (cpu_q.size() > 0 && cpu_q[0].due == cyc) cpu_last = cpu_q.pop_front().d;
        chk("cpu_rd_data", cpu_rd_data, cpu_last);
        exp_v = (dma_q.size() > 0 && dma_q[0].due == cyc);
        chk("dma_rvalid", dma_rvalid, exp_v);
        if (exp_v) dma_last = dma_q.pop_front().d;
        chk("dma_rdata", dma_rdata, dma_last);
      end
    end
  end

  initial begin
    logic wr, rd, gnt;
    logic [7:0] wa, wd, ra;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    reset = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    cpu_rd_addr = 8'h00; cpu_wr_addr = 8'h00; cpu_wr_data = 8'h00;
    dma_addr = 8'h00; dma_wdata = 8'h00;
    do_reset(2);
    // CPU read of a preloaded location
    step(1, 0, 0, 0, 1, 8'h10, 0, 0, 0, 0);
    idle(1);
    // DMA read held off by a two-cycle CPU fetch
    step(1, 0, 0, 0, 1, 8'h10, 1, 0, 8'h20, 0);
    step(1, 0, 0, 0, 1, 8'h11, 1, 0, 8'h20, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h20, 0);
    idle(2);
    // Starvation: six CPU cycles with DMA waiting, then the grant
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 8'(i), 1, 0, 8'h21, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h21, 0);
    idle(2);
    // Write/read conflict, then confirm the write landed
    step(1, 1, 8'h30, 8'h5A, 1, 8'h31, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 1, 8'h30, 0, 0, 0, 0);
    idle(2);
    // Back-to-back DMA write then read of the same address
    step(1, 0, 0, 0, 0, 0, 1, 1, 8'h40, 8'h77);
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h40, 0);
    idle(2);
    // Reset right after a granted DMA read
    step(1, 0, 0, 0, 0, 0, 1, 0, 8'h50, 0);
    do_reset(2);
    idle(2);
    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 2));
        r_dq = 1'b0;
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 2) == 0);
        wa = 8'($urandom_range(0, 15));
        wd = 8'($urandom);
        ra = 8'($urandom_range(0, 15));
        if (!r_dq && $urandom_range(0, 2) == 0) begin
          r_dq = 1'b1; r_dwe = 1'($urandom); r_da = 8'($urandom_range(0, 15)); r_dwd = 8'($urandom);
        end
        step(1, wr, wa, wd, rd, ra, r_dq, r_dwe, r_da, r_dwd);
        gnt = r_dq && !wr && !rd;
        if (gnt || (r_dq && $urandom_range(0, 15) == 0)) r_dq = 1'b0;
      end
    end
    idle(3);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
